rs232rx_buffered: RTL and testbench

RS232RX_BUFFERED -- requirements
Module: rs232rx_buffered

---
 rtl/rs232_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 49 ++++
 rtl/rs232rx_buffered.sv | 170 +++++++++++++++++
 tb/tb_rs232rx_buffered.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/rs232_pkg.sv
// Shared constants, FSM state encoding and baud divisor helper for the RS-232 receiver.
package rs232_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_t;

    // Clocks per 16x oversample tick, rounded to nearest.
    function automatic int unsigned rs232_divisor(input int unsigned freq, input int unsigned bps);
        return (freq + 8 * bps) / (16 * bps);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head word is presented combinationally on rdata.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A full FIFO still accepts a push when the head is leaving on the same edge.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/rs232rx_buffered.sv
// RS-232 receiver with 16x oversampling, majority voting, optional parity and an AXI4-Stream FIFO output.
module rs232rx_buffered
    import rs232_pkg::*;
#(
    parameter int unsigned FREQUENCY  = 25_000_000,
    parameter int unsigned BPS        = 57_600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] tdata,
    output logic [1:0]           tuser,
    output logic                 tvalid,
    input  logic                 tready,
    output logic                 overrun,
    output logic                 break_det
);

    localparam int unsigned DIV = rs232_divisor(FREQUENCY, BPS);
    localparam int unsigned CW  = $clog2(DIV + 1);
    localparam int unsigned FW  = DATA_BITS + 2;

    rx_state_t            state, state_d;
    logic                 sync1, sync2;
    logic [CW-1:0]        div_cnt, div_d;
    logic [3:0]           os_cnt, os_d;
    logic                 s7, s7_d, s8, s8_d;
    logic [3:0]           bit_cnt, bit_d;
    logic [DATA_BITS-1:0] shreg, shreg_d;
    logic                 pacc, pacc_d;
    logic                 perr, perr_d;
    logic                 pbit, pbit_d;
    logic                 brk_d;
    logic                 tick_c, mid_c, maj_c, push_c, pop_c;
    logic                 fifo_full, fifo_empty;
    logic [FW-1:0]        wdata_c, rdata;

    // Two-flop synchroniser, idles high so a fresh reset never looks like a start bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= serial_in;
            sync2 <= sync1;
        end
    end

    assign tick_c  = (div_cnt == CW'(DIV - 1));
    assign mid_c   = tick_c && (os_cnt == 4'd9);
    assign maj_c   = (s7 & s8) | (s7 & sync2) | (s8 & sync2);
    assign wdata_c = {perr, ~maj_c, shreg};

    always_comb begin
        state_d = state;
        div_d   = tick_c ? '0 : div_cnt + CW'(1);
        os_d    = tick_c ? os_cnt + 4'd1 : os_cnt;
        s7_d    = (tick_c && os_cnt == 4'd7) ? sync2 : s7;
        s8_d    = (tick_c && os_cnt == 4'd8) ? sync2 : s8;
        bit_d   = bit_cnt;
        shreg_d = shreg;
        pacc_d  = pacc;
        perr_d  = perr;
        pbit_d  = pbit;
        push_c  = 1'b0;
        brk_d   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                // Realign the oversample grid to the falling edge of the start bit.
                if (!sync2) begin
                    state_d = ST_START;
                    div_d   = '0;
                    os_d    = '0;
                    bit_d   = '0;
                    pacc_d  = 1'b0;
                    perr_d  = 1'b0;
                    pbit_d  = 1'b0;
                end
            end
            ST_START: begin
                if (mid_c) begin
                    state_d = maj_c ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (mid_c) begin
                    shreg_d = {maj_c, shreg[DATA_BITS-1:1]};
                    pacc_d  = pacc ^ maj_c;
                    bit_d   = bit_cnt + 4'd1;
                    if (bit_cnt == 4'(DATA_BITS - 1)) begin
                        state_d = (PARITY != PARITY_NONE) ? ST_PAR : ST_STOP;
                    end
                end
            end
            ST_PAR: begin
                if (mid_c) begin
                    pbit_d  = maj_c;
                    perr_d  = (PARITY == PARITY_ODD) ? ~(pacc ^ maj_c) : (pacc ^ maj_c);
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (mid_c) begin
                    push_c  = 1'b1;
                    brk_d   = ~maj_c && (shreg == '0) && ~pbit;
                    state_d = maj_c ? ST_IDLE : ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                if (sync2) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            div_cnt   <= '0;
            os_cnt    <= '0;
            s7        <= 1'b0;
            s8        <= 1'b0;
            bit_cnt   <= '0;
            shreg     <= '0;
            pacc      <= 1'b0;
            perr      <= 1'b0;
            pbit      <= 1'b0;
            overrun   <= 1'b0;
            break_det <= 1'b0;
        end else begin
            state     <= state_d;
            div_cnt   <= div_d;
            os_cnt    <= os_d;
            s7        <= s7_d;
            s8        <= s8_d;
            bit_cnt   <= bit_d;
            shreg     <= shreg_d;
            pacc      <= pacc_d;
            perr      <= perr_d;
            pbit      <= pbit_d;
            overrun   <= push_c && fifo_full && !pop_c;
            break_det <= brk_d;
        end
    end

    assign pop_c = tvalid && tready;

    sync_fifo #(
        .WIDTH(FW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock  (clock),
        .reset_n(reset_n),
        .push   (push_c),
        .wdata  (wdata_c),
        .pop    (pop_c),
        .rdata  (rdata),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign tvalid          = !fifo_empty;
    assign {tuser, tdata}  = rdata;

endmodule

// File: tb/tb_rs232rx_buffered.sv
// Directed bench: an 8N1 receiver and an 8E1 receiver driven by bit-banged serial frames.
module tb_rs232rx_buffered;
    import rs232_pkg::*;

    localparam int unsigned BIT_CLKS = 434;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       serial_a, serial_b;
    logic       tready_a, tready_b;
    logic [7:0] tdata_a, tdata_b;
    logic [1:0] tuser_a, tuser_b;
    logic       tvalid_a, tvalid_b;
    logic       overrun_a, overrun_b;
    logic       break_det_a, break_det_b;

    int         checks   = 0;
    int         failures = 0;
    logic [9:0] qa[$];
    logic [9:0] qb[$];
    int         ovr_a = 0;
    int         brk_a = 0;
    int         ovr0, brk0;

    always #20 clock = ~clock;

    rs232rx_buffered dut_a (
        .clock(clock), .reset_n(reset_n), .serial_in(serial_a),
        .tdata(tdata_a), .tuser(tuser_a), .tvalid(tvalid_a), .tready(tready_a),
        .overrun(overrun_a), .break_det(break_det_a)
    );

    rs232rx_buffered #(.PARITY(PARITY_EVEN)) dut_b (
        .clock(clock), .reset_n(reset_n), .serial_in(serial_b),
        .tdata(tdata_b), .tuser(tuser_b), .tvalid(tvalid_b), .tready(tready_b),
        .overrun(overrun_b), .break_det(break_det_b)
    );

    // Record accepted beats and pulses midway between rising edges.
    always @(negedge clock) begin
        if (reset_n) begin
            if (tvalid_a && tready_a) qa.push_back({tuser_a, tdata_a});
            if (tvalid_b && tready_b) qb.push_back({tuser_b, tdata_b});
            if (overrun_a) ovr_a++;
            if (break_det_a) brk_a++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int unsigned n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit ln, input logic v);
        if (ln) serial_b = v;
        else    serial_a = v;
    endtask

    // Start bit, nbits LSB first, one stop bit, then one idle bit time.
    task automatic send(input bit ln, input int nbits, input logic [8:0] bits);
        drive(ln, 1'b0);
        wait_clks(BIT_CLKS);
        for (int i = 0; i < nbits; i++) begin
            drive(ln, bits[i]);
            wait_clks(BIT_CLKS);
        end
        drive(ln, 1'b1);
        wait_clks(2 * BIT_CLKS);
    endtask

    initial begin
        serial_a = 1'b1;
        serial_b = 1'b1;
        tready_a = 1'b1;
        tready_b = 1'b1;
        reset_n  = 1'b0;
        wait_clks(5);
        check("rst_tvalid",  32'(tvalid_a), 32'd0);
        check("rst_tdata",   32'(tdata_a), 32'd0);
        check("rst_tuser",   32'(tuser_a), 32'd0);
        check("rst_overrun", 32'(overrun_a), 32'd0);
        check("rst_break",   32'(break_det_a), 32'd0);
        check("rst_state",   32'(dut_a.state), 32'(ST_IDLE));
        reset_n = 1'b1;
        wait_clks(5);

        // 8N1 0xA5
        send(1'b0, 8, 9'h0A5);
        check("a5_count", 32'(qa.size()), 32'd1);
        check("a5_beat",  32'(qa[0]), 32'h0A5);
        qa.delete();

        // Even parity: 0x03 with parity 1 is wrong, with parity 0 is right
        send(1'b1, 9, 9'h103);
        check("par_bad_count", 32'(qb.size()), 32'd1);
        check("par_bad_beat",  32'(qb[0]), 32'h203);
        qb.delete();
        send(1'b1, 9, 9'h003);
        check("par_ok_beat",   32'(qb.size() == 1 ? qb[0] : 10'h3FF), 32'h003);

        // Break: line low for two frame times
        brk0 = brk_a;
        drive(1'b0, 1'b0);
        wait_clks(20 * BIT_CLKS);
        check("brk_count", 32'(qa.size()), 32'd1);
        check("brk_beat",  32'(qa[0]), 32'h100);
        check("brk_pulse", 32'(brk_a - brk0), 32'd1);
        drive(1'b0, 1'b1);
        wait_clks(3 * BIT_CLKS);
        check("brk_no_more", 32'(qa.size()), 32'd1);
        check("brk_idle",    32'(dut_a.state), 32'(ST_IDLE));
        qa.delete();

        // Overrun: five frames into a four-deep FIFO with no consumer
        tready_a = 1'b0;
        ovr0 = ovr_a;
        for (int i = 1; i <= 5; i++) send(1'b0, 8, 9'(i));
        check("ovr_pulse",  32'(ovr_a - ovr0), 32'd1);
        check("ovr_tvalid", 32'(tvalid_a), 32'd1);
        check("ovr_stable", 32'(tdata_a), 32'h01);
        tready_a = 1'b1;
        wait_clks(10);
        check("ovr_drain_count", 32'(qa.size()), 32'd4);
        for (int i = 0; i < 4; i++) check($sformatf("ovr_drain%0d", i), 32'(qa[i]), 32'(i + 1));
        check("ovr_empty", 32'(tvalid_a), 32'd0);
        qa.delete();

        // Short low glitch must be rejected
        drive(1'b0, 1'b0);
        wait_clks(130);
        drive(1'b0, 1'b1);
        wait_clks(2 * BIT_CLKS);
        check("glitch_nopush", 32'(qa.size()), 32'd0);
        check("glitch_idle",   32'(dut_a.state), 32'(ST_IDLE));
        send(1'b0, 8, 9'h05A);
        check("glitch_next", 32'(qa.size() == 1 ? qa[0] : 10'h3FF), 32'h05A);
        qa.delete();

        // Reset mid-frame, with a word already waiting
        tready_a = 1'b0;
        send(1'b0, 8, 9'h011);
        check("mid_pre_tvalid", 32'(tvalid_a), 32'd1);
        drive(1'b0, 1'b0);
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, (i == 0 || i == 2) ? 1'b1 : 1'b0);
            wait_clks(BIT_CLKS);
        end
        drive(1'b0, 1'b1);
        wait_clks(BIT_CLKS / 2);
        reset_n = 1'b0;
        #1;
        check("mid_rst_tvalid", 32'(tvalid_a), 32'd0);
        check("mid_rst_tdata",  32'(tdata_a), 32'd0);
        check("mid_rst_state",  32'(dut_a.state), 32'(ST_IDLE));
        wait_clks(3);
        reset_n = 1'b1;
        wait_clks(5 * BIT_CLKS);
        qa.delete();
        tready_a = 1'b1;
        send(1'b0, 8, 9'h07E);
        check("mid_next_count", 32'(qa.size()), 32'd1);
        check("mid_next_beat",  32'(qa[0]), 32'h07E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
